// File: rtl/paint_scan.sv
// paint_scan: frame scanner, priority compositor and framebuffer writer (optional PAINT_SCAN_PERF_EN stall counter)
module paint_scan #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 480,
  parameter int LAYERS = 4,
  parameter int LATENCY = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W = 18,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     new_frame,
  output logic signed [15:0]       paint_x,
  output logic signed [15:0]       paint_y,
  input  logic [LAYERS-1:0]        paint_enable_in,
  input  logic [16*LAYERS-1:0]     paint_color_in,
  output logic                     fb_valid,
  input  logic                     fb_ready,
  output logic [ADDR_W-1:0]        fb_addr,
  output logic [15:0]              fb_data,
  output logic                     fb_last,
  output logic [31:0]              stall_cycles
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ADDR_W + 2;
  localparam int OW = $clog2(FIFO_DEPTH + LATENCY + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NEWF = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0] state;
  logic [15:0] x_cnt, y_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [LATENCY-1:0][PW-1:0] pipe;
  logic [LATENCY:0][PW-1:0] pipe_n;
  logic [ADDR_W+16:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [OW-1:0] occ;
  logic [15:0] comp;
  logic issue, last_xy, x_end, push, pop, inflight_z, done;
  // credits in use: FIFO entries plus every valid bit still travelling with the painters
  always_comb begin
    occ = OW'(count);
    inflight_z = 1'b1;
    for (int i = 0; i < LATENCY; i++) begin
      occ = occ + OW'(pipe[i][PW-1]);
      inflight_z = inflight_z & !pipe[i][PW-1];
    end
  end
  // lowest-numbered enabled layer wins, background otherwise
  always_comb begin
    comp = BG_COLOR;
    for (int i = LAYERS - 1; i >= 0; i--)
      comp = paint_enable_in[i] ? paint_color_in[16*i +: 16] : comp;
  end
  assign issue = state == SCAN && occ < OW'(FIFO_DEPTH);
  assign x_end = x_cnt == 16'(FRAME_W - 1);
  assign last_xy = x_end && y_cnt == 16'(FRAME_H - 1);
  assign pipe_n = {pipe, issue, issue && last_xy, addr_cnt};
  assign push = pipe[LATENCY-1][PW-1];
  assign pop = fb_valid && fb_ready;
  assign done = state == DRAIN && inflight_z && count == '0;
  assign busy = state != IDLE;
  assign frame_done = done;
  assign new_frame = state == NEWF;
  assign paint_x = issue ? x_cnt : '1;
  assign paint_y = issue ? y_cnt : '1;
  assign fb_valid = count != '0;
  assign fb_addr = fb_valid ? mem[rd_ptr][ADDR_W+15:16] : '0;
  assign fb_data = fb_valid ? mem[rd_ptr][15:0] : '0;
  assign fb_last = fb_valid && mem[rd_ptr][ADDR_W+16];
  // frame sequencing and raster/address counters
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
      addr_cnt <= '0;
    end else begin
      state <= state == IDLE ? (start ? NEWF : IDLE) :
               state == NEWF ? SCAN :
               state == SCAN ? (issue && last_xy ? DRAIN : SCAN) :
               (done ? IDLE : DRAIN);
      if (state == NEWF) begin
        x_cnt <= '0;
        y_cnt <= '0;
        addr_cnt <= '0;
      end else if (issue) begin
        x_cnt <= x_end ? '0 : x_cnt + 16'd1;
        y_cnt <= x_end ? y_cnt + 16'd1 : y_cnt;
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
    end
  end
  // valid/last/address ride alongside the painter latency
  always_ff @(posedge clk) begin
    if (!rstn) pipe <= '0;
    else pipe <= pipe_n[LATENCY-1:0];
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // FIFO storage, written as the composited pixel emerges
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pipe[LATENCY-1][PW-2], pipe[LATENCY-1][ADDR_W-1:0], comp};
  end
`ifdef PAINT_SCAN_PERF_EN
  logic [31:0] stall_q;
  // saturating count of SCAN cycles blocked by credits, cleared per frame
  always_ff @(posedge clk) begin
    if (!rstn) stall_q <= '0;
    else if (state == IDLE && start) stall_q <= '0;
    else if (state == SCAN && !issue && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_paint_scan.sv
// tb_paint_scan: table vectors plus randomized frames against a pixel-level reference model
module tb_paint_scan;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;
  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam int L = 4;
  typedef struct packed {logic [17:0] addr; logic [15:0] data; logic last;} pix_t;
  typedef struct {int mode; int addr; logic [15:0] exp;} vec_t;
  logic clk = 0, rstn = 0, start = 0, fb_ready = 1;
  logic busy, frame_done, new_frame, fb_valid, fb_last;
  logic signed [15:0] paint_x, paint_y;
  logic [L-1:0] paint_enable_in;
  logic [16*L-1:0] paint_color_in;
  logic [17:0] fb_addr;
  logic [15:0] fb_data;
  logic [31:0] stall_cycles;
  int nvec = 0, nerr = 0, cyc = 0, since = 0, rmode = 0, pmode = 0, seed = 0;
  int n_iss, n_acc, nf_cnt, done_cnt, blocked, nf_cyc, first_iss, last_iss, last_acc_cyc, done_cyc;
  bit scan_on = 0, hold_prev = 0;
  pix_t prev;
  pix_t acc_q[$];
  pix_t ex_q[$];
  logic signed [15:0] dx[LAT], dy[LAT];

  paint_scan #(.FRAME_W(W), .FRAME_H(H), .LAYERS(L), .LATENCY(LAT), .FIFO_DEPTH(DEP),
               .ADDR_W(18), .BG_COLOR(16'h0000)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .frame_done(frame_done),
    .new_frame(new_frame), .paint_x(paint_x), .paint_y(paint_y),
    .paint_enable_in(paint_enable_in), .paint_color_in(paint_color_in),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_last(fb_last), .stall_cycles(stall_cycles));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic pen(int m, int i, int x, int y, int s);
    if (x < 0 || y < 0) return 1'b0;
    if (m == 1) return (i == 0 && x == 1) || i == 2;
    if (m == 2) return ((x * 7 + y * 13 + i * 5 + s) % 3) == 0;
    return 1'b0;
  endfunction

  function automatic logic [15:0] pcol(int m, int i, int x, int y, int s);
    if (m == 1) return i == 0 ? 16'hF800 : i == 2 ? 16'h07E0 : 16'h001F;
    return 16'(x * 257 + y * 4099 + i * 31 + s * 3 + 1);
  endfunction

  function automatic pix_t model(int a, int m, int s);
    int x = a % W;
    int y = a / W;
    int win = -1;
    pix_t p;
    for (int i = 0; i < L; i++)
      if (win < 0 && pen(m, i, x, y, s)) win = i;
    p.addr = 18'(a);
    p.data = win < 0 ? 16'h0000 : pcol(m, win, x, y, s);
    p.last = a == N - 1;
    return p;
  endfunction

  function automatic logic [16:0] find(int a);
    foreach (acc_q[k]) if (acc_q[k].addr == 18'(a)) return {1'b1, acc_q[k].data};
    return '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // painters modelled as pure delay lines on the issued coordinates
  always @(posedge clk) begin
    dx[0] <= paint_x;
    dy[0] <= paint_y;
    for (int i = 1; i < LAT; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
    end
  end
  always_comb
    for (int i = 0; i < L; i++) begin
      paint_enable_in[i] = pen(pmode, i, int'(dx[LAT-1]), int'(dy[LAT-1]), seed);
      paint_color_in[16*i +: 16] = pcol(pmode, i, int'(dx[LAT-1]), int'(dy[LAT-1]), seed);
    end

  // observe outputs between edges
  always @(negedge clk) begin
    if (!rstn) hold_prev = 0;
    else begin
      if (paint_x != -16'sd1 || paint_y != -16'sd1) begin
        chk("coord", 64'({paint_y, paint_x}), 64'({16'(n_iss / W), 16'(n_iss % W)}));
        if (n_iss == 0) first_iss = cyc;
        if (n_iss == N - 1) begin
          last_iss = cyc;
          scan_on = 0;
        end
        n_iss++;
      end else if (scan_on) blocked++;
      if (new_frame) begin
        nf_cnt++;
        nf_cyc = cyc;
        scan_on = 1;
      end
      if (hold_prev)
        chk("hold_stable", 64'({fb_valid, fb_addr, fb_data, fb_last}), 64'({1'b1, prev}));
      hold_prev = fb_valid && !fb_ready;
      prev = {fb_addr, fb_data, fb_last};
      if (fb_valid && fb_ready) begin
        acc_q.push_back({fb_addr, fb_data, fb_last});
        n_acc++;
        if (fb_last) last_acc_cyc = cyc;
      end
      if (busy) chk("credit", 64'(n_iss - n_acc <= DEP), 64'(1));
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    since++;
    fb_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (since < 20 ? 1'b0 : 1'b1) : 1'($urandom_range(0, 1));
  endtask

  task automatic clear(input int m, input int rm);
    pmode = m;
    rmode = rm;
    seed = int'($urandom_range(0, 1000));
    n_iss = 0; n_acc = 0; nf_cnt = 0; done_cnt = 0; blocked = 0; scan_on = 0;
    first_iss = -1; last_iss = -1; last_acc_cyc = -1; done_cyc = -1; nf_cyc = -1;
    since = 0;
    acc_q.delete();
    ex_q.delete();
    for (int a = 0; a < N; a++) ex_q.push_back(model(a, m, seed));
    fb_ready = rm == 1 ? 1'b0 : 1'b1;
  endtask

  task automatic run_frame(input int m, input int rm, input bit dbl);
    clear(m, rm);
    start = 1;
    step();
    start = 0;
    chk("busy_start", 64'(busy), 64'(1));
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      step();
      if (dbl && k == 5) start = 1;
      if (dbl && k == 6) start = 0;
      if (rm == 1 && since == 20) begin
        chk("hold_fill", 64'(n_iss), 64'(DEP));
        chk("hold_none_out", 64'(n_acc), 64'(0));
      end
    end
    repeat (12) step();
    chk("done_cnt", 64'(done_cnt), 64'(1));
    chk("new_frame_cnt", 64'(nf_cnt), 64'(1));
    chk("busy_end", 64'(busy), 64'(0));
    chk("pixel_count", 64'(acc_q.size()), 64'(N));
    for (int a = 0; a < N && a < acc_q.size(); a++) chk("pixel", 64'(acc_q[a]), 64'(ex_q[a]));
    chk("newf_to_issue", 64'(first_iss - nf_cyc), 64'(1));
    chk("done_latency", 64'(done_cyc - last_acc_cyc), 64'(1));
    if (rm == 0) begin
      chk("consecutive", 64'(last_iss - first_iss + 1), 64'(N));
      chk("no_block", 64'(blocked), 64'(0));
    end
`ifdef PAINT_SCAN_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(blocked));
`else
    chk("stall_zero", 64'(stall_cycles), 64'(0));
`endif
  endtask

  vec_t tbl[10];
  int cur;

  initial begin
    tbl[0] = '{1, 0, 16'h07E0};
    tbl[1] = '{1, 1, 16'hF800};
    tbl[2] = '{1, 2, 16'h07E0};
    tbl[3] = '{1, 5, 16'hF800};
    tbl[4] = '{1, 7, 16'h07E0};
    tbl[5] = '{1, 9, 16'hF800};
    tbl[6] = '{1, 15, 16'h07E0};
    tbl[7] = '{0, 0, 16'h0000};
    tbl[8] = '{0, 6, 16'h0000};
    tbl[9] = '{0, 15, 16'h0000};
    rmode = 0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(frame_done), 64'(0));
    chk("rst_newf", 64'(new_frame), 64'(0));
    chk("rst_xy", 64'({paint_x, paint_y}), 64'(32'hFFFF_FFFF));
    chk("rst_valid", 64'({fb_valid, fb_last}), 64'(0));
    chk("rst_addr_data", 64'({fb_addr, fb_data}), 64'(0));
    chk("rst_stall", 64'(stall_cycles), 64'(0));
    rstn = 1;
    step();
    cur = -1;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].mode != cur) begin
        run_frame(tbl[i].mode, 0, 0);
        cur = tbl[i].mode;
      end
      chk("table_data", 64'(find(tbl[i].addr)), 64'({1'b1, tbl[i].exp}));
    end
    run_frame(2, 1, 0);
    chk("hold_blocked_seen", 64'(blocked > 0), 64'(1));
    for (int r = 0; r < 4; r++) run_frame(2, 2, 0);
    run_frame(2, 0, 1);
    clear(2, 0);
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 50 && n_iss < 3; k++) step();
    rstn = 0;
    step();
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_valid", 64'(fb_valid), 64'(0));
    chk("midrst_xy", 64'({paint_x, paint_y}), 64'(32'hFFFF_FFFF));
    chk("midrst_done", 64'(frame_done), 64'(0));
    rstn = 1;
    repeat (40) step();
    chk("midrst_no_done", 64'(done_cnt), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));
    run_frame(1, 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/paint_scan.md
Name: paint_scan

Overview:
- Frame-level initiator of the paint interface. Sweeps paint_x/paint_y over the frame and pulses new_frame.
- Samples the enable/colour returned by LAYERS painter pipelines of fixed latency and composites them by priority.
- Streams the resulting pixels, with framebuffer addresses, out a valid/ready write port.
- Sits between the sprite/stage painters and the framebuffer writer.

Parameters:
- FRAME_W, 320, pixels per row (x inner loop)
- FRAME_H, 480, rows per frame (y outer loop)
- LAYERS, 4, painter count; index 0 = highest priority
- LATENCY, 4, cycles from paint_x/paint_y to the matching paint_enable/paint_color
- FIFO_DEPTH, 8, output FIFO entries (power of two, >= 2)
- ADDR_W, 18, framebuffer address width
- BG_COLOR, 16'h0000, colour used when no layer is enabled

Ports:
- clk  in  1  clock
- rstn  in  1  reset: synchronous, active-low (clock clk)
- start  in  1  one-cycle request to render a frame
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse when the last pixel is accepted
- new_frame  out  1  one-cycle pulse to painters before the first coordinate
- paint_x  out  16  signed column being issued
- paint_y  out  16  signed row being issued
- paint_enable_in  in  LAYERS  per-layer enable, LATENCY cycles after its coordinate
- paint_color_in  in  16*LAYERS  per-layer RGB565; layer i at [16i+15:16i]
- fb_valid  out  1  pixel available
- fb_ready  in  1  framebuffer accepts the pixel
- fb_addr  out  ADDR_W  y*FRAME_W + x
- fb_data  out  16  composited colour
- fb_last  out  1  high with the final pixel of the frame
- stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Reset values: busy=0, frame_done=0, new_frame=0, paint_x=paint_y=16'hFFFF (-1), fb_valid=0, fb_last=0, fb_addr=0, fb_data=0, stall_cycles=0. The FIFO and the in-flight shift register are flushed.
- FSM states: IDLE, NEWF, SCAN, DRAIN.
- IDLE: start -> NEWF.
- NEWF: new_frame=1 for exactly one cycle, coordinates stay at -1. -> SCAN with x=y=0.
- SCAN: issues at most one coordinate per cycle. After issuing (FRAME_W-1, FRAME_H-1) -> DRAIN.
- DRAIN: waits until in-flight=0 and FIFO empty with the last pixel accepted. Then frame_done=1 for one cycle -> IDLE.
- start is ignored unless in IDLE.
- Idle-coordinate rule: every cycle without an issued coordinate (IDLE, NEWF, DRAIN, SCAN stall) drives paint_x=paint_y=-1, so every painter is inactive and its row counters never double-count. Coordinates are never held across a stall.
- Credit rule: issue only when FIFO_DEPTH - fifo_count - inflight > 0. inflight = number of set bits in a LATENCY-deep valid shift register, counting in the same cycle it is shifted. The FIFO can therefore never overflow, regardless of fb_ready.
- Traversal: x increments every issue; at x=FRAME_W-1 it wraps to 0 and y increments.
- Address pipeline: the address is computed incrementally (no multiplier), starting at 0 and adding 1 per issue. It travels alongside the valid bit for LATENCY cycles.
- Composite: when the delayed valid emerges, take the lowest i with paint_enable_in[i]=1 and push paint_color_in[i]; if none are enabled, push BG_COLOR. The last flag is pushed with the final pixel.
- FIFO: first-word fall-through. fb_valid = !empty; fb_addr/fb_data/fb_last come from the head entry. Pop on fb_valid && fb_ready. fb_data is held stable while fb_valid && !fb_ready.
- Simultaneous push and pop on a full FIFO cannot occur (credit rule). A push and pop in the same cycle leaves the count unchanged.
- Reset mid-frame: return to the reset state in the next cycle. The frame is abandoned and no frame_done is produced.

Optional Feature:
- Macro PAINT_SCAN_PERF_EN.
- Defined: stall_cycles clears on an accepted start and increments on each SCAN cycle where an issue was blocked by credits. Saturates at 32'hFFFFFFFF and holds after frame_done.
- Undefined: stall_cycles is constant 0 and no counter logic is generated.

Test Plan:
- FRAME_W=4, FRAME_H=2, LATENCY=4, fb_ready=1, model painters as delay lines -> new_frame exactly one cycle before the first issue; fb_addr 0..7 in order; fb_last only on addr 7; frame_done one cycle after addr 7 is accepted; 8 consecutive issue cycles.
- Layer 0 enabled for x=1 only (colour 16'hF800), layer 2 enabled everywhere (16'h07E0) -> fb_data is F800 at addresses 1 and 5, 07E0 elsewhere. With no layers enabled -> every pixel is BG_COLOR.
- fb_ready=0 for 20 cycles from frame start -> at most FIFO_DEPTH entries are held, paint_x/paint_y read -1 on every stalled cycle, and no pixel is lost or duplicated after release. With PAINT_SCAN_PERF_EN, stall_cycles matches the count of blocked SCAN cycles.
- fb_ready toggling randomly -> the output stream equals the reference model in order; fb_data is stable whenever valid is high and ready low.
- start pulsed while busy -> ignored, only one frame produced. rstn=0 mid-SCAN -> the next cycle shows busy=0, fb_valid=0, coordinates -1, and no frame_done.
- A second start after frame_done -> new_frame pulses again and the addresses restart at 0.
